// File: rtl/wb_irq_ctrl.sv
// Wishbone B3 interrupt controller: per-source polarity, edge/level mode, mask, W1C pending.
// Optional IRQ_SYNC_EN adds a two-flop synchroniser per source ahead of the sampling stage.
module wb_irq_ctrl #(
  parameter int          NUM_IRQ    = 20,
  parameter logic [31:0] RESET_MASK = 32'h0,
  parameter logic [31:0] RESET_MODE = 32'h0,
  parameter logic [31:0] RESET_POL  = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               irq_any_o
);

  localparam logic [2:0] A_STATUS = 3'd0, A_PENDING = 3'd1, A_MASK = 3'd2,
                         A_MODE = 3'd3, A_POL = 3'd4, A_SWSET = 3'd5;

  logic [NUM_IRQ-1:0] mask_q, mode_q, pol_q, pending_q, a_q, prev_q;
  logic [NUM_IRQ-1:0] irq_s, wm, wd, w1c, sws, pending_nxt, rd_sel;
  logic [31:0]        sel_bits, rd_data;
  logic [2:0]         addr;
  logic               req, wr;
  logic               unused_bits;

  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_cti_i, wb_bte_i, wb_dat_i};

  assign addr     = wb_adr_i[4:2];
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i;
  assign sel_bits = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wm       = sel_bits[NUM_IRQ-1:0];
  assign wd       = wb_dat_i[NUM_IRQ-1:0];
  assign w1c      = (wr && addr == A_PENDING) ? (wd & wm) : '0;
  assign sws      = (wr && addr == A_SWSET) ? (wd & wm & mode_q) : '0;

  // Edge sources: set (hardware edge or SWSET) beats a simultaneous W1C. Level sources follow a_q.
  assign pending_nxt = (mode_q & ((pending_q & ~w1c) | (a_q & ~prev_q) | sws))
                     | (~mode_q & a_q);

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  always_comb begin
    rd_sel = '0;
    case (addr)
      A_STATUS:  rd_sel = pending_q & mask_q;
      A_PENDING: rd_sel = pending_q;
      A_MASK:    rd_sel = mask_q;
      A_MODE:    rd_sel = mode_q;
      A_POL:     rd_sel = pol_q;
      default:   rd_sel = '0;
    endcase
    rd_data = '0;
    rd_data[NUM_IRQ-1:0] = rd_sel;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mask_q    <= RESET_MASK[NUM_IRQ-1:0];
      mode_q    <= RESET_MODE[NUM_IRQ-1:0];
      pol_q     <= RESET_POL[NUM_IRQ-1:0];
      pending_q <= '0;
      a_q       <= '0;
      prev_q    <= '0;
      irq_o     <= '0;
      irq_any_o <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      a_q       <= irq_s ^ pol_q;
      prev_q    <= a_q;
      pending_q <= pending_nxt;
      irq_o     <= pending_q & mask_q;
      irq_any_o <= |(pending_q & mask_q);
      wb_ack_o  <= req;
      wb_dat_o  <= (req && !wb_we_i) ? rd_data : '0;
      if (wr) begin
        case (addr)
          A_MASK:  mask_q <= (mask_q & ~wm) | (wd & wm);
          A_MODE:  mode_q <= (mode_q & ~wm) | (wd & wm);
          A_POL:   pol_q  <= (pol_q  & ~wm) | (wd & wm);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl (NUM_IRQ=20, default build): register-map vector table
// followed by hand-timed sequences for latency, edge/W1C collision, polarity, SWSET and reset.
module tb_wb_irq_ctrl;

  localparam int N = 20;
  localparam logic [31:0] R_STATUS = 32'h00, R_PENDING = 32'h04, R_MASK = 32'h08,
                          R_MODE = 32'h0C, R_POL = 32'h10, R_SWSET = 32'h14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   adr = '0, dat_w = '0;
  logic [3:0]    sel = '0;
  logic          we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [2:0]    cti = '0;
  logic [1:0]    bte = '0;
  logic [31:0]   dat_r;
  logic          ack, err, rty;
  logic [N-1:0]  irq = '0;
  logic [N-1:0]  irq_out;
  logic          irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_irq_ctrl #(.NUM_IRQ(N)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .irq_i(irq), .irq_o(irq_out), .irq_any_o(irq_any)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one access at posedge+1; returns read data and cycles until ack, then idles.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdat, output int lat);
    adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!ack && lat < 8);
    if (!ack) check("ack_timeout", {31'b0, ack}, 32'h1);
    rdat = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick(3);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l;
    xfer(a, 1'b1, d, 4'hF, r, l);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    xfer(a, 1'b0, 32'h0, 4'hF, r, l);
    check(name, r, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;

    vecs[0]  = '{R_MASK,    1'b0, 32'h0,        4'hF, 32'h0};
    vecs[1]  = '{R_MASK,    1'b1, 32'hFFFFFFFF, 4'h1, 32'h0};
    vecs[2]  = '{R_MASK,    1'b0, 32'h0,        4'hF, 32'h000000FF};
    vecs[3]  = '{R_MASK,    1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[4]  = '{R_MASK,    1'b0, 32'h0,        4'hF, 32'h000FFFFF};
    vecs[5]  = '{32'h18,    1'b0, 32'h0,        4'hF, 32'h0};
    vecs[6]  = '{32'h1C,    1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[7]  = '{32'h1C,    1'b0, 32'h0,        4'hF, 32'h0};
    vecs[8]  = '{R_MODE,    1'b1, 32'h0000F0F0, 4'hF, 32'h0};
    vecs[9]  = '{R_MODE,    1'b0, 32'h0,        4'hF, 32'h0000F0F0};
    vecs[10] = '{R_MODE,    1'b1, 32'hFFFFFFFF, 4'h4, 32'h0};
    vecs[11] = '{R_MODE,    1'b0, 32'h0,        4'hF, 32'h000FF0F0};
    vecs[12] = '{R_SWSET,   1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[13] = '{R_SWSET,   1'b0, 32'h0,        4'hF, 32'h0};
    vecs[14] = '{R_PENDING, 1'b0, 32'h0,        4'hF, 32'h000FF0F0};
    vecs[15] = '{R_STATUS,  1'b0, 32'h0,        4'hF, 32'h000FF0F0};
    vecs[16] = '{R_PENDING, 1'b1, 32'h0000F000, 4'hF, 32'h0};
    vecs[17] = '{R_PENDING, 1'b0, 32'h0,        4'hF, 32'h000F00F0};
    vecs[18] = '{R_MODE,    1'b1, 32'h0,        4'hF, 32'h0};
    vecs[19] = '{R_PENDING, 1'b0, 32'h0,        4'hF, 32'h0};
    vecs[20] = '{R_MASK,    1'b1, 32'h0,        4'hF, 32'h0};
    vecs[21] = '{R_STATUS,  1'b0, 32'h0,        4'hF, 32'h0};

    // Reset state
    tick(3);
    check("rst_irq_o", {12'b0, irq_out}, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    xfer(R_MASK, 1'b0, 32'h0, 4'hF, r, lat);
    check("rst_mask", r, 32'h0);
    check("rst_ack_latency", lat, 32'd1);
    rd_chk("rst_mode", R_MODE, 32'h0);
    rd_chk("rst_pending", R_PENDING, 32'h0);

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, r, lat);
      if (!vecs[i].we) check($sformatf("vec%0d", i), r, vecs[i].exp);
      else             check($sformatf("vec%0d_wr_dat_o", i), r, 32'h0);
    end

    // Level source latency and W1C immunity
    wr(R_MASK, 32'h1);
    irq[0] = 1'b1;
    tick(2);
    check("lvl_irq_o_early", {12'b0, irq_out}, 32'h0);
    tick(1);
    check("lvl_irq_o", {12'b0, irq_out}, 32'h1);
    check("lvl_irq_any", {31'b0, irq_any}, 32'h1);
    wr(R_PENDING, 32'h1);
    rd_chk("lvl_w1c_noeffect", R_PENDING, 32'h1);
    irq[0] = 1'b0;
    tick(2);
    check("lvl_fall_early", {12'b0, irq_out}, 32'h1);
    tick(1);
    check("lvl_fall", {12'b0, irq_out}, 32'h0);
    check("lvl_fall_any", {31'b0, irq_any}, 32'h0);

    // Edge source: single-cycle pulse latches, W1C clears
    wr(R_MODE, 32'h4);
    wr(R_MASK, 32'h4);
    irq[2] = 1'b1;
    tick(1);
    irq[2] = 1'b0;
    tick(4);
    check("edge_irq_o", {12'b0, irq_out}, 32'h4);
    rd_chk("edge_pending", R_PENDING, 32'h4);
    tick(10);
    rd_chk("edge_held", R_PENDING, 32'h4);
    wr(R_PENDING, 32'h4);
    rd_chk("edge_w1c", R_PENDING, 32'h0);

    // New edge lands on the same clock as the W1C write: set wins
    irq[2] = 1'b1;
    tick(1);
    adr = R_PENDING; we = 1'b1; dat_w = 32'h4; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick(1);
    check("collide_ack", {31'b0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    irq[2] = 1'b0;
    tick(3);
    rd_chk("collide_pending", R_PENDING, 32'h4);

    // Polarity inversion and SWSET gating by mode
    wr(R_MASK, 32'h8);
    wr(R_POL, 32'h8);
    tick(2);
    rd_chk("pol_status", R_STATUS, 32'h8);
    wr(R_MODE, 32'h10);
    wr(R_SWSET, 32'h10);
    rd_chk("swset_edge", R_PENDING, 32'h18);
    wr(R_PENDING, 32'h10);
    wr(R_MODE, 32'h0);
    wr(R_SWSET, 32'h10);
    rd_chk("swset_level", R_PENDING, 32'h08);
    check("pol_irq_o", {12'b0, irq_out}, 32'h8);

    // Asynchronous reset in the middle of an ack cycle
    adr = R_PENDING; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    tick(1);
    check("midrst_ack_before", {31'b0, ack}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_irq_o", {12'b0, irq_out}, 32'h0);
    check("midrst_irq_any", {31'b0, irq_any}, 32'h0);
    check("midrst_dat_o", dat_r, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rd_chk("midrst_pending", R_PENDING, 32'h0);
    rd_chk("midrst_pol", R_POL, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
